// File: rtl/regfile_write_arbiter.sv
// Two-requester round-robin arbiter for one register-file write port; 1-cycle latency.
// Backpressure: RDY is combinational and held low during STALL or reset.
module regfile_write_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             REQ0_V,
  input  logic [4:0]       REQ0_A,
  input  logic [31:0]      REQ0_D,
  output logic             REQ0_RDY,
  input  logic             REQ1_V,
  input  logic [4:0]       REQ1_A,
  input  logic [31:0]      REQ1_D,
  output logic             REQ1_RDY,
  input  logic             STALL,
  output logic             WE3,
  output logic [4:0]       A3,
  output logic [31:0]      WD3,
  output logic             LAST_GNT,
  output logic [CNT_W-1:0] WCOUNT,
  output logic             ERR
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             last_gnt_q, last_gnt_d;
  logic             we_q, we_d;
  logic             err_q, err_d;
  logic [4:0]       a3_q, a3_d;
  logic [31:0]      wd3_q, wd3_d;
  logic [CNT_W-1:0] wcount_q, wcount_d;

  logic             rdy0, rdy1;
  logic             xfer;
  logic             gnt_idx;
  logic [4:0]       sel_a;
  logic [31:0]      sel_d;
  logic             in_range;

  // On a tie the requester that did not win last time gets the port.
  always_comb begin
    rdy0 = 1'b0;
    rdy1 = 1'b0;
    if (RESET_N && !STALL) begin
      if (REQ0_V && REQ1_V) begin
        rdy0 = last_gnt_q;
        rdy1 = !last_gnt_q;
      end else begin
        rdy0 = REQ0_V;
        rdy1 = REQ1_V;
      end
    end
  end

  always_comb begin
    xfer     = rdy0 | rdy1;
    gnt_idx  = rdy1;
    sel_a    = rdy1 ? REQ1_A : REQ0_A;
    sel_d    = rdy1 ? REQ1_D : REQ0_D;
    in_range = (sel_a[4:3] == 2'b00);

    last_gnt_d = last_gnt_q;
    we_d       = 1'b0;
    err_d      = 1'b0;
    a3_d       = a3_q;
    wd3_d      = wd3_q;
    wcount_d   = wcount_q;

    if (xfer) begin
      last_gnt_d = gnt_idx;
      if (in_range) begin
        we_d  = 1'b1;
        a3_d  = sel_a;
        wd3_d = sel_d;
        if (wcount_q != CNT_MAX) begin
          wcount_d = wcount_q + CNT_ONE;
        end
      end else begin
        // Registers above r7 do not exist: accept to free the requester, then drop.
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      last_gnt_q <= 1'b1;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      a3_q       <= '0;
      wd3_q      <= '0;
      wcount_q   <= '0;
    end else begin
      last_gnt_q <= last_gnt_d;
      we_q       <= we_d;
      err_q      <= err_d;
      a3_q       <= a3_d;
      wd3_q      <= wd3_d;
      wcount_q   <= wcount_d;
    end
  end

  assign REQ0_RDY = rdy0;
  assign REQ1_RDY = rdy1;
  assign WE3      = we_q;
  assign A3       = a3_q;
  assign WD3      = wd3_q;
  assign LAST_GNT = last_gnt_q;
  assign WCOUNT   = wcount_q;
  assign ERR      = err_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed vector table plus randomized run against a reference model.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        v0 = 1'b0, v1 = 1'b0;
  logic [4:0]  a0 = '0, a1 = '0;
  logic [31:0] d0 = '0, d1 = '0;

  logic        r0, r1, we, last, err;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic [15:0] cnt;

  logic        n_r0, n_r1, n_we, n_last, n_err;
  logic [4:0]  n_a3;
  logic [31:0] n_wd3;
  logic [1:0]  n_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.CNT_W(16)) dut (
    .CLK(clk), .RESET_N(rst_n),
    .REQ0_V(v0), .REQ0_A(a0), .REQ0_D(d0), .REQ0_RDY(r0),
    .REQ1_V(v1), .REQ1_A(a1), .REQ1_D(d1), .REQ1_RDY(r1),
    .STALL(stall), .WE3(we), .A3(a3), .WD3(wd3),
    .LAST_GNT(last), .WCOUNT(cnt), .ERR(err)
  );

  regfile_write_arbiter #(.CNT_W(2)) dut_n (
    .CLK(clk), .RESET_N(rst_n),
    .REQ0_V(v0), .REQ0_A(a0), .REQ0_D(d0), .REQ0_RDY(n_r0),
    .REQ1_V(v1), .REQ1_A(a1), .REQ1_D(d1), .REQ1_RDY(n_r1),
    .STALL(stall), .WE3(n_we), .A3(n_a3), .WD3(n_wd3),
    .LAST_GNT(n_last), .WCOUNT(n_cnt), .ERR(n_err)
  );

  typedef struct {
    logic        rst_n, stall;
    logic        v0;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        r0, r1;
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
    logic        last, err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
      input logic rs, input logic st,
      input logic iv0, input logic [4:0] ia0, input logic [31:0] id0,
      input logic iv1, input logic [4:0] ia1, input logic [31:0] id1,
      input logic er0, input logic er1,
      input logic ewe, input logic [4:0] ea3, input logic [31:0] ewd3,
      input logic [15:0] ecnt, input logic [1:0] ecnt2,
      input logic elast, input logic eerr);
    vec_t v;
    v.rst_n = rs;  v.stall = st;
    v.v0 = iv0;    v.a0 = ia0;  v.d0 = id0;
    v.v1 = iv1;    v.a1 = ia1;  v.d1 = id1;
    v.r0 = er0;    v.r1 = er1;
    v.we = ewe;    v.a3 = ea3;  v.wd3 = ewd3;
    v.cnt = ecnt;  v.cnt2 = ecnt2;
    v.last = elast; v.err = eerr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model state: what the registered outputs should show now.
  bit          m_we, m_err, m_last;
  logic [4:0]  m_a3;
  logic [31:0] m_wd3;
  int          m_cnt, m_cnt2;

  task automatic run_random(input int n);
    int winner;
    logic [4:0] wa;
    logic [31:0] wdat;
    // Synchronise model and DUT with a reset cycle first.
    @(negedge clk);
    rst_n = 1'b0; stall = 1'b0; v0 = 1'b0; v1 = 1'b0;
    @(posedge clk);
    m_we = 0; m_err = 0; m_last = 1; m_a3 = '0; m_wd3 = '0; m_cnt = 0; m_cnt2 = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 39) != 0);
      stall = ($urandom_range(0, 3) == 0);
      v0    = $urandom_range(0, 1) == 1;
      v1    = $urandom_range(0, 1) == 1;
      a0    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(8, 31)) : 5'($urandom_range(0, 7));
      a1    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(8, 31)) : 5'($urandom_range(0, 7));
      d0    = $urandom;
      d1    = $urandom;
      #1;
      winner = -1;
      if (rst_n && !stall) begin
        if (v0 && v1)  winner = m_last ? 0 : 1;
        else if (v0)   winner = 0;
        else if (v1)   winner = 1;
      end
      chk("rnd rdy0", 32'(r0), 32'(winner == 0));
      chk("rnd rdy1", 32'(r1), 32'(winner == 1));
      chk("rnd we3", 32'(we), 32'(m_we));
      chk("rnd a3", 32'(a3), 32'(m_a3));
      chk("rnd wd3", wd3, m_wd3);
      chk("rnd wcount", 32'(cnt), 32'(m_cnt));
      chk("rnd wcount_narrow", 32'(n_cnt), 32'(m_cnt2));
      chk("rnd last_gnt", 32'(last), 32'(m_last));
      chk("rnd err", 32'(err), 32'(m_err));
      if (!rst_n) begin
        m_we = 0; m_err = 0; m_last = 1; m_a3 = '0; m_wd3 = '0; m_cnt = 0; m_cnt2 = 0;
      end else if (winner >= 0) begin
        wa   = (winner == 1) ? a1 : a0;
        wdat = (winner == 1) ? d1 : d0;
        m_last = (winner == 1);
        if (wa < 8) begin
          m_we = 1; m_err = 0; m_a3 = wa; m_wd3 = wdat;
          if (m_cnt < 65535) m_cnt++;
          if (m_cnt2 < 3) m_cnt2++;
        end else begin
          m_we = 0; m_err = 1;
        end
      end else begin
        m_we = 0; m_err = 0;
      end
      @(posedge clk);
    end
  endtask

  initial begin
    // rst stall | v0 a0 d0 | v1 a1 d1 || rdy0 rdy1 | we a3 wd3 cnt cnt2 last err
    vecs.push_back(mk(0,0, 1,3,32'h1,     1,4,32'h2,     0,0, 0,0,32'h0,        0,0,1,0));
    vecs.push_back(mk(1,0, 1,1,32'd11,    1,2,32'd22,    1,0, 1,1,32'd11,       1,1,0,0));
    vecs.push_back(mk(1,0, 1,1,32'd11,    1,2,32'd22,    0,1, 1,2,32'd22,       2,2,1,0));
    vecs.push_back(mk(1,0, 1,1,32'd11,    1,2,32'd22,    1,0, 1,1,32'd11,       3,3,0,0));
    vecs.push_back(mk(1,0, 1,1,32'd11,    1,2,32'd22,    0,1, 1,2,32'd22,       4,3,1,0));
    vecs.push_back(mk(1,0, 1,1,32'd11,    1,2,32'd22,    1,0, 1,1,32'd11,       5,3,0,0));
    vecs.push_back(mk(1,1, 1,7,32'd77,    1,6,32'd66,    0,0, 0,1,32'd11,       5,3,0,0));
    vecs.push_back(mk(1,1, 1,5,32'd78,    1,4,32'd67,    0,0, 0,1,32'd11,       5,3,0,0));
    vecs.push_back(mk(1,1, 1,3,32'd79,    1,0,32'd68,    0,0, 0,1,32'd11,       5,3,0,0));
    vecs.push_back(mk(1,0, 1,1,32'd11,    1,2,32'd22,    0,1, 1,2,32'd22,       6,3,1,0));
    vecs.push_back(mk(1,0, 0,0,32'd0,     1,9,32'd99,    0,1, 0,2,32'd22,       6,3,1,1));
    vecs.push_back(mk(1,0, 0,0,32'd0,     0,0,32'd0,     0,0, 0,2,32'd22,       6,3,1,0));
    vecs.push_back(mk(1,0, 1,17,32'd5,    0,0,32'd0,     1,0, 0,2,32'd22,       6,3,0,1));
    vecs.push_back(mk(1,0, 1,4,32'd44,    0,0,32'd0,     1,0, 1,4,32'd44,       7,3,0,0));
    vecs.push_back(mk(0,0, 0,0,32'd0,     0,0,32'd0,     0,0, 0,0,32'h0,        0,0,1,0));
    vecs.push_back(mk(1,0, 1,3,32'hDEADBEEF, 0,0,32'd0,  1,0, 1,3,32'hDEADBEEF, 1,1,0,0));
    vecs.push_back(mk(1,0, 0,0,32'd0,     1,5,32'd55,    0,1, 1,5,32'd55,       2,2,1,0));
    vecs.push_back(mk(0,0, 1,6,32'd66,    0,0,32'd0,     0,0, 0,0,32'h0,        0,0,1,0));
    vecs.push_back(mk(1,0, 0,0,32'd0,     0,0,32'd0,     0,0, 0,0,32'h0,        0,0,1,0));

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n = vecs[i].rst_n; stall = vecs[i].stall;
      v0 = vecs[i].v0; a0 = vecs[i].a0; d0 = vecs[i].d0;
      v1 = vecs[i].v1; a1 = vecs[i].a1; d1 = vecs[i].d1;
      #1;
      chk($sformatf("v%0d rdy0", i), 32'(r0), 32'(vecs[i].r0));
      chk($sformatf("v%0d rdy1", i), 32'(r1), 32'(vecs[i].r1));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d we3", i), 32'(we), 32'(vecs[i].we));
      chk($sformatf("v%0d a3", i), 32'(a3), 32'(vecs[i].a3));
      chk($sformatf("v%0d wd3", i), wd3, vecs[i].wd3);
      chk($sformatf("v%0d wcount", i), 32'(cnt), 32'(vecs[i].cnt));
      chk($sformatf("v%0d wcount_narrow", i), 32'(n_cnt), 32'(vecs[i].cnt2));
      chk($sformatf("v%0d last_gnt", i), 32'(last), 32'(vecs[i].last));
      chk($sformatf("v%0d err", i), 32'(err), 32'(vecs[i].err));
    end

    run_random(2000);

    // Registered outputs from the final random cycle.
    @(negedge clk);
    v0 = 1'b0; v1 = 1'b0; stall = 1'b0; rst_n = 1'b1;
    #1;
    chk("end we3", 32'(we), 32'(m_we));
    chk("end wcount", 32'(cnt), 32'(m_cnt));
    chk("end wcount_narrow", 32'(n_cnt), 32'(m_cnt2));
    chk("end last_gnt", 32'(last), 32'(m_last));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
